reg_read_stage: RTL and testbench

- Parametrised register-read pipeline stage between select/issue and execute.
- For each of ISSUE_WIDTH lanes it does the following:
  - reads two source operands from the physical register file;
  - overrides them from any of NUM_BYPASS execute bypass sources;
  - forces preg 0 to zero;
  - registers the result toward execute with per-lane valid/ready handshake and flush.
- Also keeps a saturating bypass-hit performance counter.

---
 rtl/reg_read_stage_pkg.sv | 14 +
 rtl/reg_read_stage_if.sv | 44 ++++
 rtl/reg_read_stage_bypass_resolve.sv | 47 ++++
 rtl/reg_read_stage.sv | 106 ++++++++++
 tb/tb_reg_read_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_read_stage_pkg.sv
// Shared types and defaults for the register-read stage and its operand resolvers.
package reg_read_stage_pkg;

    localparam int DEF_XLEN   = 32;
    localparam int DEF_PREG_W = 6;
    localparam int ZERO_PREG  = 0;

    typedef enum logic [1:0] {
        REG_FILE,
        BYPASS,
        ZERO
    } operand_sel_e;

endpackage

// File: rtl/reg_read_stage_if.sv
// Issue, regfile, bypass and execute-side signals of the register-read stage.
interface reg_read_stage_if #(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_BYPASS  = 4,
    parameter int PREG_W      = reg_read_stage_pkg::DEF_PREG_W,
    parameter int XLEN        = reg_read_stage_pkg::DEF_XLEN,
    parameter int UOP_W       = 64,
    parameter int CNT_W       = 32
);

    logic [ISSUE_WIDTH-1:0]          in_valid;
    logic [ISSUE_WIDTH-1:0]          in_ready;
    logic [ISSUE_WIDTH*PREG_W-1:0]   in_src1;
    logic [ISSUE_WIDTH*PREG_W-1:0]   in_src2;
    logic [ISSUE_WIDTH*UOP_W-1:0]    in_uop;
    logic [2*ISSUE_WIDTH*PREG_W-1:0] rf_raddr;
    logic [2*ISSUE_WIDTH*XLEN-1:0]   rf_rdata;
    logic [NUM_BYPASS-1:0]           byp_valid;
    logic [NUM_BYPASS*PREG_W-1:0]    byp_dst;
    logic [NUM_BYPASS*XLEN-1:0]      byp_data;
    logic                            flush;
    logic [ISSUE_WIDTH-1:0]          out_valid;
    logic [ISSUE_WIDTH-1:0]          out_ready;
    logic [ISSUE_WIDTH*XLEN-1:0]     out_src1_val;
    logic [ISSUE_WIDTH*XLEN-1:0]     out_src2_val;
    logic [ISSUE_WIDTH*UOP_W-1:0]    out_uop;
    logic [CNT_W-1:0]                perf_byp_hits;

    // The environment (issue, regfile, bypass network, execute) is the master.
    modport master (
        output in_valid, in_src1, in_src2, in_uop, rf_rdata,
               byp_valid, byp_dst, byp_data, flush, out_ready,
        input  in_ready, rf_raddr, out_valid, out_src1_val, out_src2_val,
               out_uop, perf_byp_hits
    );

    modport slave (
        input  in_valid, in_src1, in_src2, in_uop, rf_rdata,
               byp_valid, byp_dst, byp_data, flush, out_ready,
        output in_ready, rf_raddr, out_valid, out_src1_val, out_src2_val,
               out_uop, perf_byp_hits
    );

endinterface

// File: rtl/reg_read_stage_bypass_resolve.sv
// Resolves one source operand: preg 0 reads as zero, else lowest-index bypass hit, else regfile.
module reg_read_stage_bypass_resolve
    import reg_read_stage_pkg::*;
#(
    parameter int PREG_W     = DEF_PREG_W,
    parameter int XLEN       = DEF_XLEN,
    parameter int NUM_BYPASS = 4
) (
    input  logic [PREG_W-1:0]            src,
    input  logic [XLEN-1:0]              rf_val,
    input  logic [NUM_BYPASS-1:0]        byp_valid,
    input  logic [NUM_BYPASS*PREG_W-1:0] byp_dst,
    input  logic [NUM_BYPASS*XLEN-1:0]   byp_data,
    output logic [XLEN-1:0]              val,
    output logic                         hit
);

    operand_sel_e    sel;
    logic [XLEN-1:0] byp_val;

    // Scan from oldest to youngest so the lowest matching index is written last.
    always_comb begin
        sel     = REG_FILE;
        byp_val = '0;
        if (src == PREG_W'(ZERO_PREG)) begin
            sel = ZERO;
        end else begin
            for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
                if (byp_valid[k] && (byp_dst[k*PREG_W +: PREG_W] == src)) begin
                    sel     = BYPASS;
                    byp_val = byp_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        case (sel)
            ZERO:    val = '0;
            BYPASS:  val = byp_val;
            default: val = rf_val;
        endcase
    end

    assign hit = (sel == BYPASS);

endmodule

// File: rtl/reg_read_stage.sv
// Register-read pipeline stage: per-lane operand resolution, output registers with
// valid/ready/flush, and a saturating bypass-hit counter.
module reg_read_stage
    import reg_read_stage_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int NUM_BYPASS  = 4,
    parameter int PREG_W      = DEF_PREG_W,
    parameter int XLEN        = DEF_XLEN,
    parameter int UOP_W       = 64,
    parameter int CNT_W       = 32
) (
    input logic             clk,
    input logic             rst,
    reg_read_stage_if.slave bus
);

    localparam int NSRC  = 2 * ISSUE_WIDTH;
    localparam int SUM_W = CNT_W + 1;

    logic [NSRC*PREG_W-1:0]       raddr;
    logic [NSRC*XLEN-1:0]         res_val;
    logic [NSRC-1:0]              res_hit;
    logic [ISSUE_WIDTH-1:0]       capture;
    logic [ISSUE_WIDTH-1:0]       out_valid_q;
    logic [ISSUE_WIDTH*XLEN-1:0]  src1_q;
    logic [ISSUE_WIDTH*XLEN-1:0]  src2_q;
    logic [ISSUE_WIDTH*UOP_W-1:0] uop_q;
    logic [CNT_W-1:0]             perf_q;
    logic [CNT_W-1:0]             perf_next;
    logic [SUM_W-1:0]             hit_cnt;
    logic [SUM_W-1:0]             perf_sum;

    // Read port 2i carries lane i's src1 and port 2i+1 its src2.
    always_comb begin
        raddr = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            raddr[(2*i)*PREG_W   +: PREG_W] = bus.in_src1[i*PREG_W +: PREG_W];
            raddr[(2*i+1)*PREG_W +: PREG_W] = bus.in_src2[i*PREG_W +: PREG_W];
        end
    end

    for (genvar j = 0; j < NSRC; j++) begin : g_resolve
        reg_read_stage_bypass_resolve #(
            .PREG_W     (PREG_W),
            .XLEN       (XLEN),
            .NUM_BYPASS (NUM_BYPASS)
        ) u_resolve (
            .src       (raddr[j*PREG_W +: PREG_W]),
            .rf_val    (bus.rf_rdata[j*XLEN +: XLEN]),
            .byp_valid (bus.byp_valid),
            .byp_dst   (bus.byp_dst),
            .byp_data  (bus.byp_data),
            .val       (res_val[j*XLEN +: XLEN]),
            .hit       (res_hit[j])
        );
    end

    // in_ready deliberately ignores flush so it has no combinational path from it.
    assign capture = bus.in_valid & bus.in_ready;

    always_comb begin
        hit_cnt = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            if (capture[i] && !bus.flush) begin
                hit_cnt = hit_cnt + SUM_W'(res_hit[2*i]) + SUM_W'(res_hit[2*i+1]);
            end
        end
        perf_sum  = {1'b0, perf_q} + hit_cnt;
        perf_next = perf_sum[CNT_W] ? '1 : perf_sum[CNT_W-1:0];
    end

    // Flush beats capture and held entries; a stalled lane keeps its data untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            uop_q       <= '0;
            perf_q      <= '0;
        end else begin
            perf_q <= perf_next;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (bus.flush) begin
                    out_valid_q[i] <= 1'b0;
                end else if (capture[i]) begin
                    out_valid_q[i]            <= 1'b1;
                    src1_q[i*XLEN +: XLEN]    <= res_val[(2*i)*XLEN +: XLEN];
                    src2_q[i*XLEN +: XLEN]    <= res_val[(2*i+1)*XLEN +: XLEN];
                    uop_q[i*UOP_W +: UOP_W]   <= bus.in_uop[i*UOP_W +: UOP_W];
                end else if (bus.out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    assign bus.rf_raddr      = raddr;
    assign bus.in_ready      = ~out_valid_q | bus.out_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_src1_val  = src1_q;
    assign bus.out_src2_val  = src2_q;
    assign bus.out_uop       = uop_q;
    assign bus.perf_byp_hits = perf_q;

endmodule

// File: tb/tb_reg_read_stage.sv
// Directed bench for reg_read_stage: vector table plus stall, flush, async reset and saturation sequences.
module tb_reg_read_stage;

    localparam int IW = 2;
    localparam int NB = 4;
    localparam int PW = 6;
    localparam int XW = 32;
    localparam int UW = 64;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        string              name;
        logic [IW-1:0]      in_valid;
        logic [IW*PW-1:0]   src1;
        logic [IW*PW-1:0]   src2;
        logic [2*IW*XW-1:0] rf;
        logic [NB-1:0]      bvalid;
        logic [NB*PW-1:0]   bdst;
        logic [NB*XW-1:0]   bdata;
        logic [IW*UW-1:0]   uop;
        logic [IW-1:0]      exp_valid;
        logic [IW*XW-1:0]   exp_s1;
        logic [IW*XW-1:0]   exp_s2;
        int                 exp_hits;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   exp_cnt;
    vec_t vecs[6];

    reg_read_stage_if #(
        .ISSUE_WIDTH (IW), .NUM_BYPASS (NB), .PREG_W (PW),
        .XLEN (XW), .UOP_W (UW), .CNT_W (CW)
    ) bus ();

    reg_read_stage #(
        .ISSUE_WIDTH (IW), .NUM_BYPASS (NB), .PREG_W (PW),
        .XLEN (XW), .UOP_W (UW), .CNT_W (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sat_add(input int a, input int b);
        return (a + b > CNT_MAX) ? CNT_MAX : a + b;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.in_valid  = v.in_valid;
        bus.in_src1   = v.src1;
        bus.in_src2   = v.src2;
        bus.in_uop    = v.uop;
        bus.rf_rdata  = v.rf;
        bus.byp_valid = v.bvalid;
        bus.byp_dst   = v.bdst;
        bus.byp_data  = v.bdata;
        bus.flush     = 1'b0;
        bus.out_ready = '1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = 0;

        vecs[0] = '{"no_bypass", 2'b01, {6'd0, 6'd5}, {6'd0, 6'd7},
                    {32'h0, 32'h0, 32'h22, 32'h11}, 4'b0000, '0, '0,
                    {64'hB000, 64'hA000}, 2'b01, {32'h0, 32'h11}, {32'h0, 32'h22}, 0};
        vecs[1] = '{"priority", 2'b01, {6'd0, 6'd5}, {6'd0, 6'd9},
                    {32'h0, 32'h0, 32'h44, 32'h33}, 4'b1010, {6'd5, 6'd0, 6'd5, 6'd0},
                    {32'hBBBB, 32'h0, 32'hAAAA, 32'h0},
                    {64'hB001, 64'hA001}, 2'b01, {32'h0, 32'hAAAA}, {32'h0, 32'h44}, 1};
        vecs[2] = '{"preg0", 2'b01, {6'd0, 6'd0}, {6'd0, 6'd3},
                    {32'h0, 32'h0, 32'h66, 32'h55}, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd0},
                    {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF},
                    {64'hB002, 64'hA002}, 2'b01, {32'h0, 32'h0}, {32'h0, 32'h66}, 0};
        vecs[3] = '{"two_lanes", 2'b11, {6'd12, 6'd10}, {6'd10, 6'd11},
                    {32'h103, 32'h102, 32'h101, 32'h100}, 4'b0101, {6'd0, 6'd10, 6'd0, 6'd12},
                    {32'h0, 32'hC0DE, 32'h0, 32'h1234},
                    {64'hB003, 64'hA003}, 2'b11, {32'h1234, 32'hC0DE}, {32'hC0DE, 32'h101}, 3};
        vecs[4] = '{"dup_dst", 2'b10, {6'd21, 6'd20}, {6'd20, 6'd20},
                    {32'h201, 32'h200, 32'h91, 32'h90}, 4'b0011, {6'd0, 6'd0, 6'd20, 6'd20},
                    {32'h0, 32'h0, 32'hD1, 32'hD0},
                    {64'hB004, 64'hA004}, 2'b10, {32'h200, 32'h0}, {32'hD0, 32'h0}, 1};
        vecs[5] = '{"idle", 2'b00, {6'd0, 6'd20}, {6'd0, 6'd0},
                    {32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd20},
                    {32'h0, 32'h0, 32'h0, 32'hD0},
                    {64'hB005, 64'hA005}, 2'b00, '0, '0, 0};

        rst           = 1'b0;
        bus.in_valid  = '0;
        bus.in_src1   = '0;
        bus.in_src2   = '0;
        bus.in_uop    = '0;
        bus.rf_rdata  = '0;
        bus.byp_valid = '0;
        bus.byp_dst   = '0;
        bus.byp_data  = '0;
        bus.flush     = 1'b0;
        bus.out_ready = '1;
        #3;
        checkOutput("reset_out_valid", 128'(bus.out_valid), 128'(0));
        checkOutput("reset_perf", 128'(bus.perf_byp_hits), 128'(0));
        checkOutput("reset_src1", 128'(bus.out_src1_val), 128'(0));
        checkOutput("reset_uop", 128'(bus.out_uop), 128'(0));
        #9;
        rst = 1'b1;
        step();

        // Table-driven vectors, each consumed immediately by execute.
        for (int n = 0; n < 6; n++) begin
            applyStimulus(vecs[n]);
            #1;
            checkOutput({vecs[n].name, "_raddr"}, 128'(bus.rf_raddr),
                        128'({vecs[n].src2[11:6], vecs[n].src1[11:6],
                              vecs[n].src2[5:0],  vecs[n].src1[5:0]}));
            checkOutput({vecs[n].name, "_in_ready"}, 128'(bus.in_ready), 128'(2'b11));
            step();
            exp_cnt = sat_add(exp_cnt, vecs[n].exp_hits);
            checkOutput({vecs[n].name, "_valid"}, 128'(bus.out_valid), 128'(vecs[n].exp_valid));
            for (int l = 0; l < IW; l++) begin
                if (vecs[n].exp_valid[l]) begin
                    checkOutput({vecs[n].name, "_s1"}, 128'(bus.out_src1_val[l*XW +: XW]),
                                128'(vecs[n].exp_s1[l*XW +: XW]));
                    checkOutput({vecs[n].name, "_s2"}, 128'(bus.out_src2_val[l*XW +: XW]),
                                128'(vecs[n].exp_s2[l*XW +: XW]));
                    checkOutput({vecs[n].name, "_uop"}, 128'(bus.out_uop[l*UW +: UW]),
                                128'(vecs[n].uop[l*UW +: UW]));
                end
            end
            checkOutput({vecs[n].name, "_perf"}, 128'(bus.perf_byp_hits), 128'(exp_cnt));
        end

        // Stall on lane 1: held values must survive changing regfile and bypass data.
        bus.in_valid  = 2'b10;
        bus.in_src1   = {6'd13, 6'd0};
        bus.in_src2   = {6'd14, 6'd0};
        bus.in_uop    = {64'hCAFE, 64'h0};
        bus.rf_rdata  = {32'h301, 32'h300, 32'h0, 32'h0};
        bus.byp_valid = '0;
        bus.out_ready = 2'b01;
        step();
        checkOutput("stall_capture_valid", 128'(bus.out_valid), 128'(2'b10));
        for (int c = 0; c < 3; c++) begin
            bus.in_src1   = {6'd13, 6'd13};
            bus.in_uop    = {64'hDEAD, 64'h0};
            bus.rf_rdata  = {32'h500 + c, 32'h400 + c, 32'h0, 32'h0};
            bus.byp_valid = 4'b0001;
            bus.byp_dst   = {6'd0, 6'd0, 6'd0, 6'd13};
            bus.byp_data  = {32'h0, 32'h0, 32'h0, 32'hEEEE + c};
            bus.in_valid  = 2'b10;
            #1;
            checkOutput("stall_in_ready", 128'(bus.in_ready[1]), 128'(0));
            step();
            checkOutput("stall_valid", 128'(bus.out_valid[1]), 128'(1));
            checkOutput("stall_s1", 128'(bus.out_src1_val[XW +: XW]), 128'(32'h300));
            checkOutput("stall_s2", 128'(bus.out_src2_val[XW +: XW]), 128'(32'h301));
            checkOutput("stall_uop", 128'(bus.out_uop[UW +: UW]), 128'(64'hCAFE));
        end
        checkOutput("stall_perf", 128'(bus.perf_byp_hits), 128'(exp_cnt));
        bus.in_valid  = '0;
        bus.byp_valid = '0;
        bus.out_ready = 2'b11;
        step();
        checkOutput("stall_release", 128'(bus.out_valid), 128'(2'b00));
        step();
        checkOutput("stall_release_idle", 128'(bus.out_valid), 128'(2'b00));

        // Flush kills both a held entry and simultaneous captures, without counting hits.
        bus.in_valid  = 2'b01;
        bus.in_src1   = {6'd0, 6'd1};
        bus.in_src2   = {6'd0, 6'd2};
        bus.out_ready = 2'b00;
        step();
        checkOutput("flush_pre_valid", 128'(bus.out_valid), 128'(2'b01));
        bus.in_valid  = 2'b11;
        bus.in_src1   = {6'd8, 6'd8};
        bus.in_src2   = {6'd9, 6'd1};
        bus.byp_valid = 4'b0001;
        bus.byp_dst   = {6'd0, 6'd0, 6'd0, 6'd8};
        bus.byp_data  = {32'h0, 32'h0, 32'h0, 32'h77};
        bus.flush     = 1'b1;
        #1;
        checkOutput("flush_in_ready", 128'(bus.in_ready), 128'(2'b10));
        step();
        checkOutput("flush_valid", 128'(bus.out_valid), 128'(2'b00));
        checkOutput("flush_perf", 128'(bus.perf_byp_hits), 128'(exp_cnt));
        bus.flush     = 1'b0;
        bus.in_valid  = '0;
        bus.byp_valid = '0;

        // Async reset asserted mid-stall, between clock edges.
        bus.in_valid  = 2'b10;
        bus.in_src1   = {6'd15, 6'd0};
        bus.in_src2   = {6'd16, 6'd0};
        bus.in_uop    = {64'h1234_5678, 64'h0};
        bus.rf_rdata  = {32'h600, 32'h601, 32'h0, 32'h0};
        bus.out_ready = 2'b00;
        step();
        checkOutput("areset_pre_valid", 128'(bus.out_valid), 128'(2'b10));
        bus.in_valid = '0;
        #2;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        checkOutput("areset_valid", 128'(bus.out_valid), 128'(0));
        checkOutput("areset_perf", 128'(bus.perf_byp_hits), 128'(0));
        checkOutput("areset_s1", 128'(bus.out_src1_val), 128'(0));
        checkOutput("areset_uop", 128'(bus.out_uop), 128'(0));
        #2;
        rst = 1'b1;
        bus.out_ready = 2'b11;
        step();

        // Four bypassed operands per cycle drive the counter into saturation.
        bus.in_valid  = 2'b11;
        bus.in_src1   = {6'd30, 6'd31};
        bus.in_src2   = {6'd29, 6'd28};
        bus.byp_valid = 4'b1111;
        bus.byp_dst   = {6'd28, 6'd29, 6'd30, 6'd31};
        bus.byp_data  = {32'h28, 32'h29, 32'h30, 32'h31};
        for (int c = 0; c < 5; c++) begin
            step();
            exp_cnt = sat_add(exp_cnt, 4);
            checkOutput("sat_perf", 128'(bus.perf_byp_hits), 128'(exp_cnt));
        end
        checkOutput("sat_s1_lane0", 128'(bus.out_src1_val[0 +: XW]), 128'(32'h31));
        checkOutput("sat_s2_lane1", 128'(bus.out_src2_val[XW +: XW]), 128'(32'h29));
        bus.in_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
